env_line_fetch: RTL and testbench
=================================

Name: env_line_fetch

Overview:
- Upstream driver and downstream consumer of the environment tile ROM.
- For each display line, walks a 20x15 tile map and issues one ROM pixel read per cycle. It captures the 8-bit pixel returned one cycle later into a ping-pong line buffer.
- The VGA side reads the front buffer by DRAW_X while the back buffer is prefetched for the next line.

Parameters:
- H_RES, 640, visible pixels per line (multiple of 32).
- V_RES, 480, visible lines (multiple of 32).
- MAP_COLS, 20, tile columns (H_RES/32).
- MAP_ROWS, 15, tile rows (V_RES/32).

Ports:
- CLOCK_50  in  1  system clock, all logic rising-edge.
- RESET  in  1  reset, asynchronous, active-low.
- LINE_START  in  1  one-cycle pulse: swap buffers and prefetch line LINE_Y.
- LINE_Y  in  9  line to prefetch, sampled on LINE_START.
- SCROLL_X  in  10  horizontal world offset, sampled on LINE_START; valid range 0..H_RES-1.
- MAP_WE  in  1  tile map write enable.
- MAP_ADDR  in  9  tile map index = row*MAP_COLS+col; writes with index >= 300 are ignored.
- MAP_DATA  in  1  tile ID to write.
- DRAW_X  in  10  current display column.
- SPRITE_PIXEL  in  8  ROM pixel data, valid one cycle after R_ENV.
- R_ENV  out  1  ROM read enable.
- SPRITE_ID  out  1  tile ID to ROM.
- SPRITE_X  out  5  pixel column within tile.
- SPRITE_Y  out  5  pixel row within tile.
- PIXEL_OUT  out  8  front-buffer pixel for DRAW_X, registered.
- FETCH_BUSY  out  1  prefetch in progress.
- OVERRUN  out  1  sticky: LINE_START arrived while busy.

Behaviour:
- Reset (RESET=0, async):
  - state IDLE; front select 0.
  - R_ENV, SPRITE_ID, SPRITE_X, SPRITE_Y, PIXEL_OUT, FETCH_BUSY and OVERRUN all 0.
  - Tile map cleared to 0. Line buffer contents are undefined.
  - Reset mid-fetch aborts the fetch immediately.
- FSM states:
  - IDLE: on LINE_START, toggle front select, latch LINE_Y to ly and SCROLL_X to sx, clear i, go FETCH.
  - FETCH: issue read for pixel i. At i=H_RES-1, go DRAIN; otherwise i++.
  - DRAIN: one cycle, write the last returned pixel, go IDLE.
- FETCH_BUSY = (state != IDLE).
- LINE_START at T: FETCH covers T+1..T+640, DRAIN at T+641, IDLE at T+642.
- Address generation, registered outputs valid during FETCH cycles:
  - wx = i + sx; subtract H_RES if wx >= H_RES (wrap).
  - SPRITE_X = wx[4:0]; column = wx>>5.
  - SPRITE_Y = ly[4:0]; row = ly>>5.
  - SPRITE_ID = map[row*MAP_COLS+column].
  - R_ENV = 1.
- Write-back:
  - The pixel index is delayed one cycle alongside the request.
  - On the following cycle, SPRITE_PIXEL is written to back_buf[i_d1].
- Out-of-range line: if ly >= V_RES, R_ENV stays 0 for the whole fetch and the back buffer is written with 8'h00. Timing is unchanged.
- Outside FETCH, R_ENV=0 and SPRITE_* hold 0.
- LINE_START while busy:
  - OVERRUN set to 1.
  - Request ignored; no swap; current fetch completes normally.
  - OVERRUN is cleared only by reset.
- Map write on the same cycle as a map read of the same index: the read returns the old value.
- Display path:
  - PIXEL_OUT <= front_buf[DRAW_X] when DRAW_X < H_RES, else 8'h00.
  - Latency 1 cycle.
  - A swap takes effect on the cycle after LINE_START.

Optional Feature:
- Macro: ENV_SCROLL_EN.
- Defined: SCROLL_X is sampled and applied with wrap as above.
- Undefined: sx is forced to 0, the SCROLL_X port is ignored, and the wrap adder is removed; wx = i.

Test Plan:
- Release reset -> R_ENV=0, PIXEL_OUT=0, FETCH_BUSY=0, OVERRUN=0. Pulse LINE_START -> FETCH_BUSY=1 for exactly 641 cycles.
- Write map[20]=1, others 0. ROM model returns {SPRITE_ID, 2'b0, SPRITE_X}. LINE_Y=33, SCROLL_X=0, then LINE_START. First request: SPRITE_ID=1, SPRITE_Y=1, SPRITE_X=0. After completion, pulse LINE_START; DRAW_X=5 -> PIXEL_OUT=8'h85. DRAW_X=40 -> PIXEL_OUT=8'h08.
- With ENV_SCROLL_EN: SCROLL_X=630, LINE_Y=0. Request i=0 -> column 19, SPRITE_X=22. Request i=10 -> column 0, SPRITE_X=0.
- LINE_START at fetch cycle 300 -> OVERRUN=1. Fetch still ends at cycle 641. Front select is unchanged by that pulse.
- LINE_Y=480 -> R_ENV never asserts. After swap, PIXEL_OUT=0 for DRAW_X 0..639. DRAW_X=700 -> PIXEL_OUT=0.
- RESET low at fetch cycle 100 -> R_ENV=0 and FETCH_BUSY=0 the same cycle. After release, a new LINE_START fetches normally.

Source files
------------

// File: rtl/env_line_fetch_if.sv
// Bus bundle between the environment line fetcher and its surroundings:
// line control, tile-map writes, display read-out and the tile ROM port.
// "slave" is the fetcher's view; "master" is the driving side.
interface env_line_fetch_if;
   logic       LINE_START;
   logic [8:0] LINE_Y;
   logic [9:0] SCROLL_X;
   logic       MAP_WE;
   logic [8:0] MAP_ADDR;
   logic       MAP_DATA;
   logic [9:0] DRAW_X;
   logic [7:0] SPRITE_PIXEL;
   logic       R_ENV;
   logic       SPRITE_ID;
   logic [4:0] SPRITE_X;
   logic [4:0] SPRITE_Y;
   logic [7:0] PIXEL_OUT;
   logic       FETCH_BUSY;
   logic       OVERRUN;

   modport slave (
      input  LINE_START, LINE_Y, SCROLL_X, MAP_WE, MAP_ADDR, MAP_DATA,
             DRAW_X, SPRITE_PIXEL,
      output R_ENV, SPRITE_ID, SPRITE_X, SPRITE_Y, PIXEL_OUT, FETCH_BUSY,
             OVERRUN
   );

   modport master (
      output LINE_START, LINE_Y, SCROLL_X, MAP_WE, MAP_ADDR, MAP_DATA,
             DRAW_X, SPRITE_PIXEL,
      input  R_ENV, SPRITE_ID, SPRITE_X, SPRITE_Y, PIXEL_OUT, FETCH_BUSY,
             OVERRUN
   );
endinterface

// File: rtl/env_line_fetch.sv
// Environment line fetcher: walks the tile map for one display line, issues
// one tile-ROM pixel read per cycle and fills the back half of a ping-pong
// line buffer while the front half is read out by DRAW_X.
// Optional build macro ENV_SCROLL_EN: when defined, SCROLL_X is latched per
// line and applied with wrap-around; when undefined the world column equals
// the pixel index and SCROLL_X is ignored.
module env_line_fetch #(
   parameter int H_RES    = 640,
   parameter int V_RES    = 480,
   parameter int MAP_COLS = 20,
   parameter int MAP_ROWS = 15
) (
   input logic              CLOCK_50,
   input logic              RESET,
   env_line_fetch_if.slave  bus
);

   localparam int MAP_SIZE = MAP_COLS * MAP_ROWS;
   localparam logic [9:0]  H_LAST_X = 10'(H_RES - 1);
   localparam logic [9:0]  H_RES_X  = 10'(H_RES);
   localparam logic [8:0]  V_RES_Y  = 9'(V_RES);
   localparam logic [8:0]  MAP_SZ_W = 9'(MAP_SIZE);
   localparam logic [8:0]  COLS_W   = 9'(MAP_COLS);
`ifdef ENV_SCROLL_EN
   localparam logic [10:0] H_RES_W  = 11'(H_RES);
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       front_q, front_d;
   logic [8:0] ly_q, ly_d;
   logic [9:0] i_q, i_d;
`ifdef ENV_SCROLL_EN
   logic [9:0] sx_q, sx_d;
   logic [10:0] wsum_s;
`else
   logic       unused_scroll_s;
   assign unused_scroll_s = ^bus.SCROLL_X;
`endif

   // Request generation (next-cycle values for the registered ROM port)
   logic       req_d, r_env_d, id_d, busy_d;
   logic [4:0] x_d, y_d;
   logic [9:0] wx_s;
   logic [3:0] row_s;
   logic [4:0] col_s;
   logic [8:0] map_idx_s;
   logic       tile_s;

   // Registered outputs and write-back pipeline
   logic       r_env_q, id_q, busy_q, overrun_q;
   logic [4:0] x_q, y_q;
   logic       req_q, wr_q;
   logic [9:0] req_idx_q, wr_idx_q;
   logic [7:0] pix_q;
   logic [7:0] wr_data_s, rd_pix_s;

   logic       map_q [0:MAP_SIZE-1];
   logic [7:0] buf0 [0:H_RES-1];
   logic [7:0] buf1 [0:H_RES-1];

   // FSM state register plus per-line context latched at line start
   always_ff @(posedge CLOCK_50 or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         front_q <= 1'b0;
         ly_q    <= 9'd0;
         i_q     <= 10'd0;
`ifdef ENV_SCROLL_EN
         sx_q    <= 10'd0;
`endif
      end else begin
         state_q <= state_d;
         front_q <= front_d;
         ly_q    <= ly_d;
         i_q     <= i_d;
`ifdef ENV_SCROLL_EN
         sx_q    <= sx_d;
`endif
      end
   end

   // FSM next state: a line start is honoured only from IDLE
   always_comb begin
      state_d = state_q;
      front_d = front_q;
      ly_d    = ly_q;
      i_d     = i_q;
`ifdef ENV_SCROLL_EN
      sx_d    = sx_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.LINE_START) begin
               state_d = ST_FETCH;
               front_d = ~front_q;
               ly_d    = bus.LINE_Y;
               i_d     = 10'd0;
`ifdef ENV_SCROLL_EN
               sx_d    = bus.SCROLL_X;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (i_q == H_LAST_X) begin
               state_d = ST_DRAIN;
            end else begin
               i_d = i_q + 10'd1;
            end
         end
         ST_DRAIN: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: ROM address for the pixel that will be requested next cycle
   always_comb begin
      req_d  = (state_d == ST_FETCH);
      busy_d = (state_d != ST_IDLE);
`ifdef ENV_SCROLL_EN
      wsum_s = {1'b0, i_d} + {1'b0, sx_d};
      if (wsum_s >= H_RES_W) begin
         wsum_s = wsum_s - H_RES_W;
      end else begin
         wsum_s = wsum_s;
      end
      wx_s = wsum_s[9:0];
`else
      wx_s = i_d;
`endif
      row_s     = ly_d[8:5];
      col_s     = wx_s[9:5];
      map_idx_s = ({5'd0, row_s} * COLS_W) + {4'd0, col_s};
      if (map_idx_s < MAP_SZ_W) begin
         tile_s = map_q[map_idx_s];
      end else begin
         tile_s = 1'b0;
      end
      if (req_d) begin
         r_env_d = (ly_d < V_RES_Y);
         id_d    = tile_s;
         x_d     = wx_s[4:0];
         y_d     = ly_d[4:0];
      end else begin
         r_env_d = 1'b0;
         id_d    = 1'b0;
         x_d     = 5'd0;
         y_d     = 5'd0;
      end
   end

   // Tile map storage; out-of-range indices are dropped, reset clears it
   always_ff @(posedge CLOCK_50 or negedge RESET) begin
      if (!RESET) begin
         for (int k = 0; k < MAP_SIZE; k++) begin
            map_q[k] <= 1'b0;
         end
      end else if (bus.MAP_WE && (bus.MAP_ADDR < MAP_SZ_W)) begin
         map_q[bus.MAP_ADDR] <= bus.MAP_DATA;
      end
   end

   // Registered ROM port, busy/overrun flags and the one-cycle index delay
   always_ff @(posedge CLOCK_50 or negedge RESET) begin
      if (!RESET) begin
         r_env_q   <= 1'b0;
         id_q      <= 1'b0;
         x_q       <= 5'd0;
         y_q       <= 5'd0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         req_q     <= 1'b0;
         req_idx_q <= 10'd0;
         wr_q      <= 1'b0;
         wr_idx_q  <= 10'd0;
      end else begin
         r_env_q   <= r_env_d;
         id_q      <= id_d;
         x_q       <= x_d;
         y_q       <= y_d;
         busy_q    <= busy_d;
         req_q     <= req_d;
         req_idx_q <= i_d;
         wr_q      <= req_q;
         wr_idx_q  <= req_idx_q;
         if (bus.LINE_START && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
         end else begin
            overrun_q <= overrun_q;
         end
      end
   end

   // Lines below the screen fill the back buffer with black instead of ROM data
   always_comb begin
      if (ly_q >= V_RES_Y) begin
         wr_data_s = 8'h00;
      end else begin
         wr_data_s = bus.SPRITE_PIXEL;
      end
   end

   // Back-buffer write of the pixel returned for last cycle's request
   always_ff @(posedge CLOCK_50) begin
      if (wr_q) begin
         if (front_q) begin
            buf0[wr_idx_q] <= wr_data_s;
         end else begin
            buf1[wr_idx_q] <= wr_data_s;
         end
      end
   end

   // Front-buffer lookup for the display column; off-screen columns are black
   always_comb begin
      if (bus.DRAW_X < H_RES_X) begin
         rd_pix_s = front_q ? buf1[bus.DRAW_X] : buf0[bus.DRAW_X];
      end else begin
         rd_pix_s = 8'h00;
      end
   end

   // Registered display pixel
   always_ff @(posedge CLOCK_50 or negedge RESET) begin
      if (!RESET) begin
         pix_q <= 8'h00;
      end else begin
         pix_q <= rd_pix_s;
      end
   end

   assign bus.R_ENV      = r_env_q;
   assign bus.SPRITE_ID  = id_q;
   assign bus.SPRITE_X   = x_q;
   assign bus.SPRITE_Y   = y_q;
   assign bus.PIXEL_OUT  = pix_q;
   assign bus.FETCH_BUSY = busy_q;
   assign bus.OVERRUN    = overrun_q;

endmodule

// File: tb/tb_env_line_fetch.sv
// Self-checking bench for env_line_fetch: directed line fetches with a tile
// ROM model returning {SPRITE_ID, 2'b00, SPRITE_X}, plus a table of display
// read-out vectors.
module tb_env_line_fetch;

   logic CLOCK_50;
   logic RESET;
   int   checks;
   int   failures;

   env_line_fetch_if bus ();

   env_line_fetch dut (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .bus      (bus.slave)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Tile ROM model: one-cycle read latency; idle cycles return junk
   always @(posedge CLOCK_50) begin
      bus.SPRITE_PIXEL <= bus.R_ENV ? {bus.SPRITE_ID, 2'b00, bus.SPRITE_X} : 8'hEE;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [9:0] draw_x;
      logic [7:0] exp_pix;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic map_write(input logic [8:0] addr, input logic data);
      @(negedge CLOCK_50);
      bus.MAP_WE   = 1'b1;
      bus.MAP_ADDR = addr;
      bus.MAP_DATA = data;
      @(negedge CLOCK_50);
      bus.MAP_WE   = 1'b0;
   endtask

   task automatic disp_chk(input string name, input logic [9:0] x, input logic [7:0] exp);
      @(negedge CLOCK_50);
      bus.DRAW_X = x;
      @(negedge CLOCK_50);
      chk(name, bus.PIXEL_OUT, exp);
   endtask

   // Pulse LINE_START, then count busy and R_ENV cycles; optional extra pulse
   // at busy cycle ovr_at; snapshot the request ports at i=0 and i=10.
   task automatic run_fetch(input logic [8:0] ly, input logic [9:0] sx, input int ovr_at,
                            output int busy_cnt, output int renv_cnt,
                            output logic [11:0] r0, output logic [11:0] r10);
      @(negedge CLOCK_50);
      bus.LINE_Y     = ly;
      bus.SCROLL_X   = sx;
      bus.LINE_START = 1'b1;
      @(negedge CLOCK_50);
      bus.LINE_START = 1'b0;
      busy_cnt = 0;
      renv_cnt = 0;
      r0  = 12'hFFF;
      r10 = 12'hFFF;
      while (bus.FETCH_BUSY && busy_cnt < 2000) begin
         if (busy_cnt == 0)  r0  = {bus.R_ENV, bus.SPRITE_ID, bus.SPRITE_Y, bus.SPRITE_X};
         if (busy_cnt == 10) r10 = {bus.R_ENV, bus.SPRITE_ID, bus.SPRITE_Y, bus.SPRITE_X};
         if (bus.R_ENV) renv_cnt++;
         bus.LINE_START = (busy_cnt == ovr_at);
         busy_cnt++;
         @(negedge CLOCK_50);
      end
      bus.LINE_START = 1'b0;
   endtask

   int          busy_n;
   int          renv_n;
   logic [11:0] req0;
   logic [11:0] req10;

   initial begin
      checks   = 0;
      failures = 0;

      // Front buffer holds line 33 with map[20]=1: column 0 -> ID 1
      vecs[0] = '{10'd5,   8'h85};
      vecs[1] = '{10'd40,  8'h08};
      vecs[2] = '{10'd0,   8'h80};
      vecs[3] = '{10'd31,  8'h9F};
      vecs[4] = '{10'd32,  8'h00};
      vecs[5] = '{10'd63,  8'h1F};
      vecs[6] = '{10'd639, 8'h1F};
      vecs[7] = '{10'd640, 8'h00};
      vecs[8] = '{10'd700, 8'h00};
      vecs[9] = '{10'd20,  8'h94};

      RESET          = 1'b0;
      bus.LINE_START = 1'b0;
      bus.LINE_Y     = 9'd0;
      bus.SCROLL_X   = 10'd0;
      bus.MAP_WE     = 1'b0;
      bus.MAP_ADDR   = 9'd0;
      bus.MAP_DATA   = 1'b0;
      bus.DRAW_X     = 10'd0;
      repeat (3) @(negedge CLOCK_50);
      RESET = 1'b1;
      @(negedge CLOCK_50);

      chk("rst_r_env",   bus.R_ENV, 0);
      chk("rst_pixel",   bus.PIXEL_OUT, 0);
      chk("rst_busy",    bus.FETCH_BUSY, 0);
      chk("rst_overrun", bus.OVERRUN, 0);
      chk("rst_sprite",  {bus.SPRITE_ID, bus.SPRITE_Y, bus.SPRITE_X}, 0);

      map_write(9'd20, 1'b1);
      map_write(9'd19, 1'b1);
      map_write(9'd300, 1'b1);

      // Line 33 into buffer 0
      run_fetch(9'd33, 10'd0, -1, busy_n, renv_n, req0, req10);
      chk("A_busy_len", busy_n, 641);
      chk("A_renv_len", renv_n, 640);
      chk("A_req_i0",   req0,  {1'b1, 1'b1, 5'd1, 5'd0});
      chk("A_req_i10",  req10, {1'b1, 1'b1, 5'd1, 5'd10});
      chk("A_idle_port", {bus.R_ENV, bus.SPRITE_ID, bus.SPRITE_Y, bus.SPRITE_X}, 0);
      chk("A_overrun",  bus.OVERRUN, 0);

      // Off-screen line 480 into buffer 1; swap shows line 33
      run_fetch(9'd480, 10'd0, -1, busy_n, renv_n, req0, req10);
      chk("B_busy_len", busy_n, 641);
      chk("B_renv_len", renv_n, 0);
      for (int v = 0; v < 10; v++) begin
         disp_chk($sformatf("disp_x%0d", vecs[v].draw_x), vecs[v].draw_x, vecs[v].exp_pix);
      end

      // Line 0 into buffer 0 with a stray LINE_START mid-fetch
      run_fetch(9'd0, 10'd0, 300, busy_n, renv_n, req0, req10);
      chk("C_busy_len", busy_n, 641);
      chk("C_renv_len", renv_n, 640);
      chk("C_overrun",  bus.OVERRUN, 1);
      for (int x = 0; x < 640; x++) begin
         disp_chk($sformatf("blank_x%0d", x), 10'(x), 8'h00);
      end
      disp_chk("blank_x700", 10'd700, 8'h00);

      // Scrolled line 0 into buffer 1; swap shows unscrolled line 0
      run_fetch(9'd0, 10'd630, -1, busy_n, renv_n, req0, req10);
      chk("D_busy_len", busy_n, 641);
`ifdef ENV_SCROLL_EN
      chk("D_req_i0",  req0,  {1'b1, 1'b1, 5'd0, 5'd22});
      chk("D_req_i10", req10, {1'b1, 1'b0, 5'd0, 5'd0});
`else
      chk("D_req_i0",  req0,  {1'b1, 1'b0, 5'd0, 5'd0});
      chk("D_req_i10", req10, {1'b1, 1'b0, 5'd0, 5'd10});
`endif
      disp_chk("D_disp_x5",   10'd5,   8'h05);
      disp_chk("D_disp_x620", 10'd620, 8'h8C);
      chk("D_overrun", bus.OVERRUN, 1);

      // Reset in the middle of a fetch
      @(negedge CLOCK_50);
      bus.LINE_Y     = 9'd33;
      bus.SCROLL_X   = 10'd0;
      bus.LINE_START = 1'b1;
      @(negedge CLOCK_50);
      bus.LINE_START = 1'b0;
      repeat (99) @(negedge CLOCK_50);
      chk("E_pre_r_env", bus.R_ENV, 1);
      RESET = 1'b0;
      #1;
      chk("E_rst_r_env",   bus.R_ENV, 0);
      chk("E_rst_busy",    bus.FETCH_BUSY, 0);
      chk("E_rst_overrun", bus.OVERRUN, 0);
      @(negedge CLOCK_50);
      RESET = 1'b1;
      run_fetch(9'd33, 10'd0, -1, busy_n, renv_n, req0, req10);
      chk("E_busy_len", busy_n, 641);
      chk("E_renv_len", renv_n, 640);
      chk("E_req_i0",   req0, {1'b1, 1'b0, 5'd1, 5'd0});
      chk("E_overrun",  bus.OVERRUN, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
